// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared field widths, FSM encoding and word-select helper for the
//            direct-mapped read-only instruction cache.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int ICACHE_TAG_W = 3;
  localparam int ICACHE_IDX_W = 3;
  localparam int ICACHE_OFF_W = 2;
  localparam int LINE_W       = 128;
  localparam int WORD_W       = 32;

  // Controller states, kept as plain sized constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t MEM_READ = 2'd1;
  localparam state_t UPDATE   = 2'd2;

  // Pick one 32-bit word out of a line; word 0 lives in bits [31:0].
  function automatic logic [WORD_W-1:0] select_word(
    input logic [LINE_W-1:0]       line,
    input logic [ICACHE_OFF_W-1:0] off
  );
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_array
// Purpose  : Valid/tag/data storage for the instruction cache. Valid bits are
//            cleared by the asynchronous reset; tag and data are not. One
//            synchronous write port, one combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int DATA_W    = LINE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ICACHE_IDX_W-1:0] rd_index,
  output logic                    rd_valid,
  output logic [ICACHE_TAG_W-1:0] rd_tag,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    wr_en,
  input  logic [ICACHE_IDX_W-1:0] wr_index,
  input  logic [ICACHE_TAG_W-1:0] wr_tag,
  input  logic [DATA_W-1:0]       wr_data
);

  logic [NUM_LINES-1:0]    valid;
  logic [ICACHE_TAG_W-1:0] tag_arr  [NUM_LINES];
  logic [DATA_W-1:0]       data_arr [NUM_LINES];

  // Valid bits: cleared on reset, set when a line is installed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload: no reset, only written on install.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_arr[wr_index]  <= wr_tag;
      data_arr[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_arr[rd_index];
  assign rd_data  = data_arr[rd_index];

endmodule
`default_nettype wire

// File: rtl/instr_cache.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache
// Purpose  : Direct-mapped read-only instruction cache. Hits return the word
//            in the same cycle; misses stall via busy_wait while a 4-word block
//            is fetched from instruction memory and installed.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [31:0]       instruction,
  output logic              busy_wait,
  output logic              IMread,
  output logic [ADDR_W-5:0] IMaddress,
  input  logic [LINE_W-1:0] IMreaddata,
  input  logic              IMbusy_wait
);

  localparam int BLK_W = ADDR_W - 4;

  // Address fields of the live request.
  logic [ICACHE_OFF_W-1:0] offset;
  logic [ICACHE_IDX_W-1:0] index;
  logic [ICACHE_TAG_W-1:0] tag;
  logic [1:0]              unused_byte_bits;

  assign offset           = address[3:2];
  assign index            = address[6:4];
  assign tag              = address[ADDR_W-1:7];
  assign unused_byte_bits = address[1:0];

  state_t             state;
  logic               wait_seen;
  logic [BLK_W-1:0]   blk_addr;
  logic [LINE_W-1:0]  line_buf;

  logic                    line_valid;
  logic [ICACHE_TAG_W-1:0] line_tag;
  logic [LINE_W-1:0]       line_data;
  logic                    hit;
  logic                    fill_en;

  icache_line_array #(
    .NUM_LINES (NUM_BLOCKS),
    .DATA_W    (WORDS_PER_BLOCK * WORD_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_index (blk_addr[ICACHE_IDX_W-1:0]),
    .wr_tag   (blk_addr[BLK_W-1 -: ICACHE_TAG_W]),
    .wr_data  (line_buf)
  );

  assign hit     = line_valid && (line_tag == tag);
  assign fill_en = (state == UPDATE);

  // Miss controller: latch block address, wait out memory handshake, install.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_seen <= 1'b0;
      blk_addr  <= '0;
      line_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !hit) begin
            blk_addr <= address[ADDR_W-1:4];
            state    <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (IMbusy_wait) begin
            wait_seen <= 1'b1;
          end else if (wait_seen) begin
            line_buf <= IMreaddata;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          wait_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so a stalled PC is released
  // immediately, even if a request is still being presented.
  assign IMread      = (state == MEM_READ);
  assign IMaddress   = blk_addr;
  assign busy_wait   = rst && ((state != IDLE) || (read && !hit));
  assign instruction = (rst && (state == IDLE) && read && hit)
                       ? select_word(line_data, offset) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_instr_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_cache
// Purpose  : Self-checking bench for instr_cache with a behavioural memory and
//            a residency model of which blocks the cache should hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd;
  logic [9:0]   addr;
  logic [31:0]  instruction;
  logic         busy_wait;
  logic         IMread;
  logic [5:0]   IMaddress;
  logic [127:0] IMreaddata;
  logic         IMbusy_wait;

  int vectors    = 0;
  int miscompares = 0;

  // Instruction memory contents (word addressed) and its access latency.
  logic [31:0] mem [256];
  int          lat;
  int          cnt;

  // Reference model: which block each line holds.
  bit          mvalid [8];
  logic [2:0]  mtag   [8];

  always #5 clk = ~clk;

  instr_cache #(.ADDR_W(10), .NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (rd),
    .address     (addr),
    .instruction (instruction),
    .busy_wait   (busy_wait),
    .IMread      (IMread),
    .IMaddress   (IMaddress),
    .IMreaddata  (IMreaddata),
    .IMbusy_wait (IMbusy_wait)
  );

  // Memory: busy for 'lat' cycles once a read is requested, then data valid.
  always @(posedge clk) begin
    if (IMread) cnt <= cnt + 1;
    else        cnt <= 0;
  end
  assign IMbusy_wait = IMread && (cnt < lat);
  assign IMreaddata  = (IMread && !IMbusy_wait)
                       ? {mem[{IMaddress, 2'd3}], mem[{IMaddress, 2'd2}],
                          mem[{IMaddress, 2'd1}], mem[{IMaddress, 2'd0}]}
                       : {4{32'hDEADBEEF}};

  function automatic bit model_hit(input logic [9:0] a);
    return mvalid[a[6:4]] && (mtag[a[6:4]] == a[9:7]);
  endfunction

  task automatic model_fill(input logic [9:0] a);
    mvalid[a[6:4]] = 1'b1;
    mtag[a[6:4]]   = a[9:7];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  // Present one fetch and follow it until busy_wait drops (bounded).
  // stalls = cycles with busy_wait after the request cycle; imr = IMread cycles.
  task automatic access(input logic [9:0] a, output logic miss, output int stalls,
                        output int imr, output logic [5:0] ima,
                        output logic [31:0] ins);
    int guard;
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1;
    miss = busy_wait; stalls = 0; imr = 0; ima = '0; guard = 0;
    while (busy_wait && guard < 200) begin
      @(posedge clk); @(negedge clk); #1;
      guard++;
      if (IMread) begin imr++; ima = IMaddress; end
      if (busy_wait) stalls++;
    end
    ins = instruction;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd = 1'b1; addr = 10'h000; lat = 5;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy_wait !== 1'b0 || IMread !== 1'b0 || instruction !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b imread=%b instr=%h required 0/0/0", busy_wait, IMread, instruction);
    end
    rd = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    vectors++;
    if (busy_wait !== 1'b0 || instruction !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b instr=%h required 0/0", busy_wait, instruction);
    end
  endtask

  task automatic test_cold_miss();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    lat = 5;
    access(10'h000, miss, st, imr, ima, ins);
    model_fill(10'h000);
    vectors++;
    if (miss !== 1'b1 || st != lat + 2 || imr != lat + 1 || ima !== 6'h00 || ins !== 32'h1) begin
      miscompares++;
      $display("FAIL cold_miss: miss=%b stalls=%0d imread=%0d imaddr=%h instr=%h required 1/%0d/%0d/00/00000001",
               miss, st, imr, ima, ins, lat + 2, lat + 1);
    end
  endtask

  task automatic test_spatial_hit();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    for (int w = 1; w < 4; w++) begin
      access(10'(w * 4), miss, st, imr, ima, ins);
      vectors++;
      if (miss !== 1'b0 || st != 0 || imr != 0 || ins !== 32'(w + 1)) begin
        miscompares++;
        $display("FAIL spatial_hit w%0d: miss=%b stalls=%0d imread=%0d instr=%h required 0/0/0/%h",
                 w, miss, st, imr, ins, 32'(w + 1));
      end
    end
  endtask

  task automatic test_conflict();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    lat = int'($urandom_range(1, 6));
    access(10'h080, miss, st, imr, ima, ins);
    model_fill(10'h080);
    vectors++;
    if (miss !== 1'b1 || st != lat + 2 || ima !== 6'h08 || ins !== mem[8'h20]) begin
      miscompares++;
      $display("FAIL conflict_fill: miss=%b stalls=%0d imaddr=%h instr=%h required 1/%0d/08/%h",
               miss, st, ima, ins, lat + 2, mem[8'h20]);
    end
    access(10'h000, miss, st, imr, ima, ins);
    model_fill(10'h000);
    vectors++;
    if (miss !== 1'b1 || ima !== 6'h00 || ins !== 32'h1) begin
      miscompares++;
      $display("FAIL conflict_refetch: miss=%b imaddr=%h instr=%h required 1/00/00000001", miss, ima, ins);
    end
  endtask

  task automatic test_distinct();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    logic [9:0] seq [2];
    logic       exp_miss;
    seq[0] = 10'h010; seq[1] = 10'h3FC;
    lat = 3;
    for (int i = 0; i < 2; i++) begin
      exp_miss = !model_hit(seq[i]);
      access(seq[i], miss, st, imr, ima, ins);
      model_fill(seq[i]);
      vectors++;
      if (miss !== exp_miss || ima !== (exp_miss ? seq[i][9:4] : 6'h00) || ins !== mem[seq[i][9:2]]) begin
        miscompares++;
        $display("FAIL distinct_fill %h: miss=%b imaddr=%h instr=%h required %b/%h/%h",
                 seq[i], miss, ima, ins, exp_miss, seq[i][9:4], mem[seq[i][9:2]]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      access(seq[i % 2], miss, st, imr, ima, ins);
      vectors++;
      if (miss !== 1'b0 || imr != 0 || ins !== mem[seq[i % 2][9:2]]) begin
        miscompares++;
        $display("FAIL distinct_alt %h: miss=%b imread=%0d instr=%h required 0/0/%h",
                 seq[i % 2], miss, imr, ins, mem[seq[i % 2][9:2]]);
      end
    end
  endtask

  task automatic test_reset_mid_miss();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    lat = 6;
    @(negedge clk); rd = 1'b1; addr = 10'h040;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (IMread !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_miss_active: imread=%b required 1", IMread);
    end
    rst = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (IMread !== 1'b0 || busy_wait !== 1'b0 || instruction !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_miss_reset: imread=%b busy=%b instr=%h required 0/0/0", IMread, busy_wait, instruction);
    end
    @(negedge clk); rst = 1'b1; rd = 1'b0;
    lat = 2;
    access(10'h000, miss, st, imr, ima, ins);
    model_fill(10'h000);
    vectors++;
    if (miss !== 1'b1 || st != lat + 2 || ins !== 32'h1) begin
      miscompares++;
      $display("FAIL after_reset_miss: miss=%b stalls=%0d instr=%h required 1/%0d/00000001", miss, st, ins, lat + 2);
    end
  endtask

  task automatic test_read_drop();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    int guard;
    lat = 3;
    @(negedge clk); rd = 1'b1; addr = 10'h1A8;
    @(negedge clk); rd = 1'b0;
    #1;
    vectors++;
    if (busy_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL read_drop_busy: busy=%b required 1", busy_wait);
    end
    guard = 0;
    while (busy_wait && guard < 50) begin @(negedge clk); #1; guard++; end
    model_fill(10'h1A8);
    access(10'h1A8, miss, st, imr, ima, ins);
    vectors++;
    if (guard >= 50 || miss !== 1'b0 || ins !== mem[8'h6A]) begin
      miscompares++;
      $display("FAIL read_drop_fill: cycles=%0d miss=%b instr=%h required <50/0/%h", guard, miss, ins, mem[8'h6A]);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rd = 1'b0; addr = 10'($urandom);
      #1;
      vectors++;
      if (busy_wait !== 1'b0 || instruction !== 32'h0 || IMread !== 1'b0) begin
        miscompares++;
        $display("FAIL idle %h: busy=%b instr=%h imread=%b required 0/0/0", addr, busy_wait, instruction, IMread);
      end
    end
  endtask

  task automatic test_random();
    logic miss; int st, imr; logic [5:0] ima; logic [31:0] ins;
    logic [9:0] a;
    logic       exp_miss;
    for (int i = 0; i < 40; i++) begin
      a = {3'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 2'($urandom)};
      lat = int'($urandom_range(1, 6));
      exp_miss = !model_hit(a);
      access(a, miss, st, imr, ima, ins);
      model_fill(a);
      vectors++;
      if (miss !== exp_miss || st != (exp_miss ? lat + 2 : 0) || imr != (exp_miss ? lat + 1 : 0)
          || (exp_miss && ima !== a[9:4]) || ins !== mem[a[9:2]]) begin
        miscompares++;
        $display("FAIL random %h: miss=%b stalls=%0d imread=%0d imaddr=%h instr=%h required %b/%0d/%0d/%h/%h",
                 a, miss, st, imr, ima, ins, exp_miss, exp_miss ? lat + 2 : 0,
                 exp_miss ? lat + 1 : 0, a[9:4], mem[a[9:2]]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 4) ? 32'(i + 1) : $urandom;
    addr = '0; rd = 1'b0; rst = 1'b0; lat = 5;
    test_reset();
    test_cold_miss();
    test_spatial_hit();
    test_conflict();
    test_distinct();
    test_reset_mid_miss();
    test_read_drop();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
